// File: rtl/simon_core_param.sv
// Iterative SIMON block cipher core for every standard (N, M, T, z) set, one round per clock.
// Latency: T cycles from ldData to doneData; key expansion takes T-M cycles from ldKey to doneKey.
// Backpressure: cipher and doneData hold until readData; key and data requests wait while the other side is busy.
module simon_core_param #(
    parameter int N  = 24,
    parameter int M  = 4,
    parameter int T  = 36,
    parameter int J  = 1,
    parameter int Co = 6
) (
    input  logic             clk,
    input  logic             nR,
    input  logic             newData,
    input  logic             enc_dec,
    input  logic             readData,
    input  logic [2*N-1:0]   plain,
    input  logic             newKey,
    input  logic [M*N-1:0]   key,
    output logic             ldData,
    output logic             doneData,
    output logic             ldKey,
    output logic             doneKey,
    output logic [2*N-1:0]   cipher
);

    localparam bit LEGAL =
        ((N == 16 && M == 4 && T == 32 && J == 0) || (N == 24 && M == 3 && T == 36 && J == 0) ||
         (N == 24 && M == 4 && T == 36 && J == 1) || (N == 32 && M == 3 && T == 42 && J == 2) ||
         (N == 32 && M == 4 && T == 44 && J == 3) || (N == 48 && M == 2 && T == 52 && J == 2) ||
         (N == 48 && M == 3 && T == 54 && J == 3) || (N == 64 && M == 2 && T == 68 && J == 2) ||
         (N == 64 && M == 3 && T == 69 && J == 3) || (N == 64 && M == 4 && T == 72 && J == 4)) &&
        (Co >= $clog2(T + 1));

    if (!LEGAL) begin : g_illegal
        $error("simon_core_param: unsupported (N, M, T, J, Co) combination");
    end

    localparam int AW = $clog2(T);
    localparam logic [Co-1:0] LAST = Co'(T - 1);

    // Bit 61 is sequence index 0 (leftmost).
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
    localparam logic [61:0] ZJ = (J == 0) ? Z0 : (J == 1) ? Z1 : (J == 2) ? Z2 : (J == 3) ? Z3 : Z4;

    typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} dstate_t;
    typedef enum logic [1:0] {K_IDLE, K_EXP, K_VALID} kstate_t;

    dstate_t d_st, d_nxt;
    kstate_t k_st, k_nxt;

    logic [N-1:0]  rk [0:T-1];
    logic [N-1:0]  x, y, nx, ny, kr, rk_new, tmp;
    logic          mode;
    logic [Co-1:0] rnd, kc, i3;
    logic [5:0]    zc;
    logic          start_d, start_k;

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] f(input logic [N-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    // Data wins a tie with a key request; the key load simply waits.
    assign start_d  = (d_st == D_IDLE) && newData && doneKey;
    assign start_k  = (d_st == D_IDLE) && !start_d && newKey && (k_st != K_EXP);
    assign doneData = (d_st == D_DONE);
    assign doneKey  = (k_st == K_VALID);

    always_comb begin
        d_nxt = d_st;
        case (d_st)
            D_IDLE:  if (start_d) d_nxt = D_RUN;
            D_RUN:   if (rnd == LAST) d_nxt = D_DONE;
            D_DONE:  if (readData) d_nxt = D_IDLE;
            default: d_nxt = D_IDLE;
        endcase
    end

    always_comb begin
        k_nxt = k_st;
        case (k_st)
            K_IDLE, K_VALID: if (start_k) k_nxt = K_EXP;
            K_EXP:           if (kc == LAST) k_nxt = K_VALID;
            default:         k_nxt = K_IDLE;
        endcase
    end

    always_comb begin
        kr = rk[AW'(mode ? rnd : (LAST - rnd))];
        nx = y;
        ny = x;
        if (mode) nx = y ^ f(x) ^ kr;
        else      ny = x ^ f(y) ^ kr;
    end

    always_comb begin
        i3     = (M == 4) ? (kc - Co'(3)) : (kc - Co'(1));
        tmp    = rol(rk[AW'(kc - Co'(1))], N - 3);
        if (M == 4) tmp = tmp ^ rk[AW'(i3)];
        tmp    = tmp ^ rol(tmp, N - 1);
        rk_new = ~rk[AW'(kc - Co'(M))] ^ tmp ^ N'(ZJ[6'd61 - zc]) ^ N'(3);
    end

    always_ff @(posedge clk) begin
        if (!nR) begin
            d_st <= D_IDLE;
            k_st <= K_IDLE;
        end else begin
            d_st <= d_nxt;
            k_st <= k_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!nR) begin
            ldData <= 1'b0;
            ldKey  <= 1'b0;
            cipher <= '0;
            x      <= '0;
            y      <= '0;
            mode   <= 1'b0;
            rnd    <= '0;
            kc     <= '0;
            zc     <= '0;
        end else begin
            ldData <= start_d;
            ldKey  <= start_k;
            if (start_d) begin
                x    <= plain[2*N-1:N];
                y    <= plain[N-1:0];
                mode <= enc_dec;
                rnd  <= '0;
            end else if (d_st == D_RUN) begin
                x   <= nx;
                y   <= ny;
                rnd <= rnd + Co'(1);
                if (rnd == LAST) cipher <= {nx, ny};
            end
            if (start_k) begin
                kc <= Co'(M);
                zc <= '0;
            end else if (k_st == K_EXP) begin
                kc <= kc + Co'(1);
                zc <= (zc == 6'd61) ? 6'd0 : zc + 6'd1;
            end
        end
    end

    // Round-key table is deliberately unreset; it is rewritten on every key load.
    always_ff @(posedge clk) begin
        if (nR && start_k) begin
            for (int i = 0; i < M; i++) rk[i] <= key[i*N +: N];
        end else if (nR && k_st == K_EXP) begin
            rk[AW'(kc)] <= rk_new;
        end
    end

endmodule

// File: tb/tb_simon_core_param.sv
// Directed bench for simon_core_param: SIMON48/96 and SIMON32/64 vectors, handshakes and reset.
module tb_simon_core_param;

    localparam logic [95:0] K96 = 96'h1a1918_121110_0a0908_020100;
    localparam logic [47:0] P48 = 48'h726963_20646e;
    localparam logic [47:0] C48 = 48'h6e06a5_acf156;
    localparam logic [63:0] K64 = 64'h1918_1110_0908_0100;
    localparam logic [31:0] P32 = 32'h6565_6877;
    localparam logic [31:0] C32 = 32'hc69b_e9bb;

    logic        clk = 1'b0;
    logic        nR = 1'b0;
    logic        newData = 1'b0, enc_dec = 1'b0, readData = 1'b0, newKey = 1'b0;
    logic [47:0] plain = '0;
    logic [95:0] key = '0;
    logic        ldData, doneData, ldKey, doneKey;
    logic [47:0] cipher;

    logic        newData_s = 1'b0, enc_dec_s = 1'b0, readData_s = 1'b0, newKey_s = 1'b0;
    logic [31:0] plain_s = '0;
    logic [63:0] key_s = '0;
    logic        ldData_s, doneData_s, ldKey_s, doneKey_s;
    logic [31:0] cipher_s;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    simon_core_param #(.N(24), .M(4), .T(36), .J(1), .Co(6)) dut (
        .clk(clk), .nR(nR), .newData(newData), .enc_dec(enc_dec), .readData(readData),
        .plain(plain), .newKey(newKey), .key(key), .ldData(ldData), .doneData(doneData),
        .ldKey(ldKey), .doneKey(doneKey), .cipher(cipher));

    simon_core_param #(.N(16), .M(4), .T(32), .J(0), .Co(6)) dut32 (
        .clk(clk), .nR(nR), .newData(newData_s), .enc_dec(enc_dec_s), .readData(readData_s),
        .plain(plain_s), .newKey(newKey_s), .key(key_s), .ldData(ldData_s), .doneData(doneData_s),
        .ldKey(ldKey_s), .doneKey(doneKey_s), .cipher(cipher_s));

    // Returns cycle counts to ldKey and from ldKey to doneKey; -1 marks a timeout.
    task automatic load_key(input logic [95:0] k, output int ld_cyc, output int done_cyc);
        ld_cyc = -1;
        done_cyc = -1;
        key = k;
        newKey = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ldKey) begin ld_cyc = i; break; end
        end
        newKey = 1'b0;
        if (ld_cyc > 0)
            for (int i = 1; i <= 200; i++) begin
                @(negedge clk);
                if (doneKey) begin done_cyc = i; break; end
            end
    endtask

    // Runs one block and reads it out; lat is ldData-to-doneData in cycles, -1 on timeout.
    task automatic run_block(input logic [47:0] p, input logic e, output logic [47:0] c, output int lat);
        int ld;
        ld = -1;
        lat = -1;
        c = '0;
        plain = p;
        enc_dec = e;
        newData = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ldData) begin ld = i; break; end
        end
        newData = 1'b0;
        if (ld > 0) begin
            for (int i = 1; i <= 200; i++) begin
                @(negedge clk);
                if (doneData) begin lat = i; break; end
            end
            if (lat > 0) begin
                c = cipher;
                readData = 1'b1;
                @(negedge clk);
                readData = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        nR = 1'b0;
        repeat (2) @(negedge clk);
        n_chk += 5;
        if (ldData !== 1'b0)  begin n_fail++; $display("FAIL reset_ldData got %b want 0", ldData); end
        if (ldKey !== 1'b0)   begin n_fail++; $display("FAIL reset_ldKey got %b want 0", ldKey); end
        if (doneData !== 1'b0) begin n_fail++; $display("FAIL reset_doneData got %b want 0", doneData); end
        if (doneKey !== 1'b0) begin n_fail++; $display("FAIL reset_doneKey got %b want 0", doneKey); end
        if (cipher !== 48'h0) begin n_fail++; $display("FAIL reset_cipher got %h want 0", cipher); end
        nR = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_no_key();
        int seen;
        seen = 0;
        plain = P48;
        enc_dec = 1'b1;
        newData = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (ldData) seen++;
        end
        newData = 1'b0;
        n_chk++;
        if (seen !== 0) begin n_fail++; $display("FAIL no_key_ldData got %0d pulses want 0", seen); end
    endtask

    task automatic test_key_load();
        int ld, dn;
        load_key(K96, ld, dn);
        n_chk += 2;
        if (ld !== 1)  begin n_fail++; $display("FAIL key_ldKey_cycle got %0d want 1", ld); end
        if (dn !== 32) begin n_fail++; $display("FAIL key_doneKey_cycles got %0d want 32", dn); end
    endtask

    task automatic test_encrypt();
        logic [47:0] c;
        int lat;
        run_block(P48, 1'b1, c, lat);
        n_chk += 2;
        if (c !== C48)  begin n_fail++; $display("FAIL enc48_cipher got %h want %h", c, C48); end
        if (lat !== 36) begin n_fail++; $display("FAIL enc48_latency got %0d want 36", lat); end
    endtask

    task automatic test_decrypt();
        logic [47:0] c;
        int lat;
        run_block(C48, 1'b0, c, lat);
        n_chk += 2;
        if (c !== P48)  begin n_fail++; $display("FAIL dec48_plain got %h want %h", c, P48); end
        if (lat !== 36) begin n_fail++; $display("FAIL dec48_latency got %0d want 36", lat); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] pts [5];
        logic [47:0] ct [5];
        logic [47:0] c;
        int lat;
        pts[0] = 48'h000000_000000;
        pts[1] = 48'hffffff_ffffff;
        pts[2] = 48'h123456_abcdef;
        pts[3] = 48'h800000_000001;
        pts[4] = 48'ha5a5a5_5a5a5a;
        for (int i = 0; i < 5; i++) begin
            run_block(pts[i], 1'b1, ct[i], lat);
            n_chk++;
            if (lat !== 36) begin n_fail++; $display("FAIL b2b_enc_latency[%0d] got %0d want 36", i, lat); end
        end
        for (int i = 0; i < 5; i++) begin
            run_block(ct[i], 1'b0, c, lat);
            n_chk++;
            if (c !== pts[i]) begin n_fail++; $display("FAIL b2b_roundtrip[%0d] got %h want %h", i, c, pts[i]); end
        end
    endtask

    task automatic test_simon32();
        int dn, lat;
        dn = -1;
        lat = -1;
        key_s = K64;
        newKey_s = 1'b1;
        for (int i = 0; i < 60 && !ldKey_s; i++) @(negedge clk);
        newKey_s = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (doneKey_s) begin dn = i; break; end
        end
        plain_s = P32;
        enc_dec_s = 1'b1;
        newData_s = 1'b1;
        for (int i = 0; i < 60 && !ldData_s; i++) @(negedge clk);
        newData_s = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (doneData_s) begin lat = i; break; end
        end
        n_chk += 3;
        if (dn !== 28)        begin n_fail++; $display("FAIL s32_doneKey_cycles got %0d want 28", dn); end
        if (lat !== 32)       begin n_fail++; $display("FAIL s32_latency got %0d want 32", lat); end
        if (cipher_s !== C32) begin n_fail++; $display("FAIL s32_cipher got %h want %h", cipher_s, C32); end
        readData_s = 1'b1;
        @(negedge clk);
        readData_s = 1'b0;
    endtask

    task automatic test_newkey_during_run();
        int early, ld, dn, lat;
        logic [47:0] c;
        early = 0;
        ld = -1;
        dn = -1;
        plain = P48;
        enc_dec = 1'b1;
        newData = 1'b1;
        for (int i = 0; i < 60 && !ldData; i++) @(negedge clk);
        newData = 1'b0;
        key = K96;
        newKey = 1'b1;
        for (int i = 0; i < 60 && !doneData; i++) begin
            @(negedge clk);
            if (ldKey) early++;
        end
        repeat (5) begin
            @(negedge clk);
            if (ldKey) early++;
        end
        n_chk += 2;
        if (early !== 0)     begin n_fail++; $display("FAIL run_newKey_ignored got %0d ldKey pulses want 0", early); end
        if (doneData !== 1'b1) begin n_fail++; $display("FAIL run_doneData_held got %b want 1", doneData); end
        readData = 1'b1;
        @(negedge clk);
        readData = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ldKey) begin ld = i; break; end
        end
        newKey = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (doneKey) begin dn = i; break; end
        end
        run_block(P48, 1'b1, c, lat);
        n_chk += 3;
        if (ld !== 1)  begin n_fail++; $display("FAIL run_ldKey_after_read got %0d want 1", ld); end
        if (dn !== 32) begin n_fail++; $display("FAIL run_reload_doneKey got %0d want 32", dn); end
        if (c !== C48) begin n_fail++; $display("FAIL run_reload_cipher got %h want %h", c, C48); end
    endtask

    task automatic test_reset_mid_run();
        int ld, dn, lat;
        logic [47:0] c;
        plain = P48;
        enc_dec = 1'b1;
        newData = 1'b1;
        for (int i = 0; i < 60 && !ldData; i++) @(negedge clk);
        newData = 1'b0;
        repeat (10) @(negedge clk);
        nR = 1'b0;
        @(negedge clk);
        n_chk += 4;
        if (ldData !== 1'b0)  begin n_fail++; $display("FAIL midrst_ldData got %b want 0", ldData); end
        if (doneData !== 1'b0) begin n_fail++; $display("FAIL midrst_doneData got %b want 0", doneData); end
        if (doneKey !== 1'b0) begin n_fail++; $display("FAIL midrst_doneKey got %b want 0", doneKey); end
        if (cipher !== 48'h0) begin n_fail++; $display("FAIL midrst_cipher got %h want 0", cipher); end
        nR = 1'b1;
        @(negedge clk);
        load_key(K96, ld, dn);
        run_block(P48, 1'b1, c, lat);
        n_chk += 2;
        if (dn !== 32) begin n_fail++; $display("FAIL midrst_doneKey_cycles got %0d want 32", dn); end
        if (c !== C48) begin n_fail++; $display("FAIL midrst_cipher_after got %h want %h", c, C48); end
    endtask

    task automatic test_hold();
        int bad, ld, lat;
        bad = 0;
        ld = -1;
        lat = -1;
        plain = P48;
        enc_dec = 1'b1;
        newData = 1'b1;
        for (int i = 0; i < 60 && !ldData; i++) @(negedge clk);
        newData = 1'b0;
        for (int i = 0; i < 60 && !doneData; i++) @(negedge clk);
        plain = C48;
        enc_dec = 1'b0;
        newData = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (doneData !== 1'b1 || cipher !== C48 || ldData !== 1'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) begin n_fail++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
        readData = 1'b1;
        @(negedge clk);
        readData = 1'b0;
        n_chk++;
        if (doneData !== 1'b0) begin n_fail++; $display("FAIL hold_doneData_clear got %b want 0", doneData); end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ldData) begin ld = i; break; end
        end
        newData = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (doneData) begin lat = i; break; end
        end
        n_chk += 3;
        if (ld !== 1)     begin n_fail++; $display("FAIL hold_next_ldData got %0d want 1", ld); end
        if (lat !== 36)   begin n_fail++; $display("FAIL hold_next_latency got %0d want 36", lat); end
        if (cipher !== P48) begin n_fail++; $display("FAIL hold_next_plain got %h want %h", cipher, P48); end
        readData = 1'b1;
        @(negedge clk);
        readData = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_key();
        test_key_load();
        test_encrypt();
        test_decrypt();
        test_back_to_back();
        test_simon32();
        test_newkey_during_run();
        test_reset_mid_run();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/simon_core_param.md
# simon_core_param

Parametrised, iterative SIMON block cipher core covering every standard SIMON (N, M, T, z-sequence) configuration. It performs one round per clock and supports per-block encrypt/decrypt selection. Round keys are expanded once per key load, held in an internal register file, and reused for any number of data blocks. It replaces fixed-configuration cores such as SIMON_4896 and keeps their newData/ldData/doneData/readData and newKey/ldKey/doneKey handshakes.

## Interface
- N, 24, word size in bits (16, 24, 32, 48, 64)
- M, 4, key words (2, 3, 4)
- T, 36, round count
- J, 1, z-sequence index (0..4)
- Co, 6, round/key counter width; must satisfy Co ≥ clog2(T+1)
- clk  in  1  single clock, all logic on rising edge
- nR  in  1  reset; synchronous, active-low
- newData  in  1  block request, level-sensitive
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled with plain
- readData  in  1  consumer has taken cipher
- plain  in  2N  input block {x, y}, x in upper half
- newKey  in  1  key load request, level-sensitive
- key  in  M×N  key[0] = k0 … key[M-1] = k(M-1)
- ldData  out  1  one-cycle pulse: plain/enc_dec captured
- doneData  out  1  cipher valid, held until read
- ldKey  out  1  one-cycle pulse: key captured
- doneKey  out  1  round-key table valid
- cipher  out  2N  result block {x, y}

## Operation
- Legal (N,M,T,J) sets are (16,4,32,0), (24,3,36,0), (24,4,36,1), (32,3,42,2), (32,4,44,3), (48,2,52,2), (48,3,54,3), (64,2,68,2), (64,3,69,3), (64,4,72,4). Any other combination is an elaboration error.
- f(x) = (x⋘1 & x⋘8) ^ (x⋘2). All arithmetic is mod 2^N.
- Encrypt round i: (x, y) ← (y ^ f(x) ^ rk[i], x), for i = 0..T-1.
- Decrypt round: (x, y) ← (y, x ^ f(y) ^ rk[i]), for i = T-1 down to 0.
- Key schedule:
  - rk[0..M-1] = key[0..M-1].
  - For i ≥ M: tmp = rk[i-1]⋙3. If M = 4, tmp ^= rk[i-3]. Then tmp ^= tmp⋙1.
  - rk[i] = ~rk[i-M] ^ tmp ^ z_J[(i-M) mod 62] ^ 3.
  - z_J is the standard SIMON 62-bit sequence, leftmost bit = index 0.
- Key FSM states:
  - KIDLE → KEXP on newKey=1 while the data FSM is IDLE.
  - KEXP → KVALID after rk[T-1] is written.
  - KVALID → KEXP on newKey=1 while the data FSM is IDLE.
  - In KEXP, newKey is ignored.
- Data FSM states:
  - IDLE → RUN on newData=1 && doneKey=1.
  - RUN → DONE after round T-1.
  - DONE → IDLE on readData=1.
- newData is ignored while doneKey=0. newKey is ignored while the data FSM is not IDLE. If both are high in IDLE with doneKey=1, data wins; the key load waits.
- Requests are level-sensitive. The requester deasserts newData before the block returns to IDLE and newKey within T-M cycles of ldKey, otherwise the request is re-accepted.

## Timing
- Reset (nR=0 at an edge): ldData=0, ldKey=0, doneData=0, doneKey=0, cipher=0. Both FSMs go idle. rk contents are don't-care. Reset mid-round or mid-expansion aborts the operation; a fresh newKey is required afterwards.
- Key load:
  - Edge K0 samples newKey. ldKey=1 for cycle K0+1, doneKey drops at K0.
  - rk[M..T-1] are written one per edge, K0+1 … K0+(T-M).
  - doneKey=1 after edge K0+(T-M).
- Data:
  - Edge D0 captures plain and enc_dec. ldData=1 for one cycle after D0.
  - Rounds run on edges D0+1 … D0+T.
  - doneData=1 and cipher valid after edge D0+T, so latency is T cycles from ldData rise.
- cipher holds its value from doneData rise until the next D0 capture, unchanged through readData.
- readData sampled high in DONE clears doneData at that edge. The earliest next capture is the following edge, giving T+2 cycles per block minimum.
- readData outside DONE is ignored.

## Test plan
- SIMON48/96 (N=24, M=4, T=36, J=1), key {1a1918, 121110, 0a0908, 020100}, encrypt 72696320646e → cipher 6e06a5acf156. doneKey at +32 cycles; doneData exactly 36 cycles after ldData.
- Same key, decrypt 6e06a5acf156 → 72696320646e. Then five back-to-back encrypt blocks without reloading the key, each round-trip checked by decrypt.
- SIMON32/64 (16, 4, 32, 0), key {1918, 1110, 0908, 0100}, encrypt 65656877 → c69be9bb.
- newData asserted before any key load: no ldData until doneKey=1. newKey asserted during RUN: no ldKey until after readData completes the block.
- nR pulsed low mid-RUN at round 10: all outputs 0 next cycle. After reload of the key and data, the correct vector is produced.
- readData held low for 20 cycles in DONE: doneData and cipher stay stable; a second newData is not accepted until readData.
